tick_scheduler: RTL and testbench

Shared clock-enable scheduler for the panel logic. It runs NUM_CH independent programmable dividers from the single system clock. Each channel emits one-cycle `tick` strobes and a divided square wave `sclk`, as used by display scan, word advance and blink timing. Periods are reprogrammed at runtime through a valid/ready handshake, and each change is applied glitch-free at the target channel's next period boundary.

---
 rtl/tick_sched_pkg.sv | 14 +
 rtl/tick_channel.sv | 62 ++++++
 rtl/tick_scheduler.sv | 97 +++++++++
 tb/tb_tick_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler: config FSM states and the
// default period/counter width.
package tick_sched_pkg;

  localparam int CNT_W = 30;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  typedef logic [CNT_W-1:0] period_t;

endpackage

// File: rtl/tick_channel.sv
// One programmable divider: period P, counter C, registered tick/sclk/active.
// A load replaces P and clears C; the wrap output tells the config FSM when a boundary occurs.
module tick_channel #(
  parameter int          CNT_W          = tick_sched_pkg::CNT_W,
  parameter int unsigned DEFAULT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  output logic             tick,
  output logic             sclk,
  output logic             active,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic             tick_q, sclk_q, active_q;
  logic             advance;

  assign advance = enable && (p_q != '0);
  assign wrap    = advance && (c_q == p_q - 1'b1);

  // A load on a wrap cycle still lets the wrap tick under the old period.
  always_comb begin
    p_d = p_q;
    c_d = c_q;
    if (load) begin
      p_d = load_period;
      c_d = '0;
    end else if (advance) begin
      c_d = wrap ? '0 : c_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q      <= DEF_P;
      c_q      <= '0;
      tick_q   <= 1'b0;
      sclk_q   <= 1'b0;
      active_q <= (DEF_P != '0);
    end else begin
      p_q      <= p_d;
      c_q      <= c_d;
      tick_q   <= wrap;
      active_q <= (p_d != '0);
      if (wrap) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

  assign tick   = tick_q;
  assign sclk   = sclk_q;
  assign active = active_q;

endmodule

// File: rtl/tick_scheduler.sv
// NUM_CH independent clock-enable dividers with a single-outstanding config port;
// period changes land on the target channel's next period boundary.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = tick_sched_pkg::CNT_W,
  parameter int unsigned DEFAULT_PERIOD = 1,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] active,
  output cfg_state_t        dbg_state
);

  cfg_state_t        state_q;
  logic              ready_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  period_q;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] load;
  logic              ch_ok;
  logic              apply;

  assign ch_ok = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
  assign apply = (state_q == PENDING) &&
                 (wrap[ch_q] || !active[ch_q] || !enable);

  always_comb begin
    load = '0;
    if (apply) begin
      load[ch_q] = 1'b1;
    end
  end

  // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_ready then drops until the cycle after the period is applied.
  // Requests to a nonexistent channel transfer and are dropped without leaving IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      ch_q     <= '0;
      period_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid && ch_ok) begin
            ch_q     <= cfg_ch;
            period_q <= cfg_period;
            state_q  <= PENDING;
            ready_q  <= 1'b0;
          end
        end
        PENDING: begin
          if (apply) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load[i]),
      .load_period (period_q),
      .tick        (tick[i]),
      .sclk        (sclk[i]),
      .active      (active[i]),
      .wrap        (wrap[i])
    );
  end

  assign cfg_ready = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NUM_CH = 3;
  localparam int TB_CNT_W = 8;
  localparam int W = 11;
  localparam logic [W-1:0] FULL = '1;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_ch;
  logic [TB_CNT_W-1:0] cfg_period;
  logic [2:0]          tick, sclk, active;
  cfg_state_t          dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  tick_scheduler #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (TB_CNT_W),
    .DEFAULT_PERIOD (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .tick       (tick),
    .sclk       (sclk),
    .active     (active),
    .dbg_state  (dbg_state)
  );

  // Layout: [10] pending, [9] cfg_ready, [8:6] tick, [5:3] sclk, [2:0] active
  function automatic logic [W-1:0] ov(input logic rdy, input logic [2:0] t,
                                      input logic [2:0] s, input logic [2:0] a);
    return {~rdy, rdy, t, s, a};
  endfunction

  function automatic logic [W-1:0] ch_mask(input int i);
    logic [W-1:0] m;
    m = {2'b11, 9'b0};
    m[6+i] = 1'b1;
    m[3+i] = 1'b1;
    m[i]   = 1'b1;
    return m;
  endfunction

  localparam logic [W-1:0] RST = {1'b0, 1'b1, 3'b000, 3'b000, 3'b111};

  always @(negedge clk) begin
    logic [W-1:0] obs, e, m;
    string nm;
    if (exp_q.size() != 0) begin
      obs = {dbg_state == PENDING, cfg_ready, tick, sclk, active};
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ((obs & m) != (e & m)) begin
        errors++;
        $display("FAIL %s t=%0t got=%b want=%b mask=%b", nm, $time, obs, e, m);
      end
    end
  end

  task automatic step(input string nm, input logic [W-1:0] m, input logic [W-1:0] e);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enable     = 1'($urandom_range(0, 1));
      cfg_valid  = 1'($urandom_range(0, 1));
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = TB_CNT_W'($urandom_range(0, 255));
      step("reset", FULL, RST);
    end
    reset      = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [TB_CNT_W-1:0] p);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0;
    @(posedge clk);
    #1;

    // Steady division: ch0/ch2 at P=1, ch1 set to P=3 while disabled
    do_reset();
    send_cfg(2'd1, 8'd3);
    step("a_idle", FULL, ov(1'b1, 3'b000, 3'b000, 3'b111));
    cfg_valid = 1'b0;
    step("a_accept", FULL, ov(1'b0, 3'b000, 3'b000, 3'b111));
    enable = 1'b1;
    step("a_apply", FULL, ov(1'b1, 3'b000, 3'b000, 3'b111));
    for (int n = 3; n <= 14; n++) begin
      logic t1, s1, par;
      t1  = (n >= 5) && ((n - 2) % 3 == 0);
      s1  = (((n - 2) / 3) % 2) == 1;
      par = (n % 2) == 1;
      step("a_div", FULL, ov(1'b1, {1'b1, t1, 1'b1}, {par, s1, par}, 3'b111));
    end

    // Mid-period reconfigure: ch1 P=5 -> P=2, accepted when C becomes 1
    do_reset();
    send_cfg(2'd1, 8'd5);
    step("b_idle", FULL, ov(1'b1, 3'b000, 3'b000, 3'b111));
    cfg_valid = 1'b0;
    step("b_accept", FULL, ov(1'b0, 3'b000, 3'b000, 3'b111));
    enable = 1'b1;
    send_cfg(2'd1, 8'd2);
    step("b_apply", FULL, ov(1'b1, 3'b000, 3'b000, 3'b111));
    cfg_valid = 1'b0;
    for (int n = 3; n <= 13; n++) begin
      logic rdy, t1, s1;
      rdy = (n >= 7);
      t1  = (n >= 7) && ((n - 7) % 2 == 0);
      s1  = (n >= 7) && ((((n - 7) / 2) % 2) == 0);
      step("b_reconf", ch_mask(1), ov(rdy, {1'b0, t1, 1'b0}, {1'b0, s1, 1'b0}, 3'b111));
    end

    // Enable low during PENDING: applied next cycle, everything frozen
    do_reset();
    enable = 1'b1;
    step("c_rst", FULL, RST);
    enable = 1'b0;
    send_cfg(2'd0, 8'd4);
    step("c_run", FULL, ov(1'b1, 3'b111, 3'b111, 3'b111));
    cfg_valid = 1'b0;
    step("c_accept", FULL, ov(1'b0, 3'b000, 3'b111, 3'b111));
    step("c_apply", FULL, ov(1'b1, 3'b000, 3'b111, 3'b111));
    enable = 1'b1;
    step("c_frozen", FULL, ov(1'b1, 3'b000, 3'b111, 3'b111));
    for (int n = 5; n <= 12; n++) begin
      logic t0, s0;
      t0 = (n == 8) || (n == 12);
      s0 = (n < 8) || (n == 12);
      step("c_reen", ch_mask(0), ov(1'b1, {2'b00, t0}, {2'b00, s0}, 3'b111));
    end

    // Disable ch0 with P=0, then a request to nonexistent channel 3
    do_reset();
    enable = 1'b1;
    step("d_rst", FULL, RST);
    send_cfg(2'd0, 8'd0);
    step("d_run", FULL, ov(1'b1, 3'b111, 3'b111, 3'b111));
    cfg_valid = 1'b0;
    step("d_accept", FULL, ov(1'b0, 3'b111, 3'b000, 3'b111));
    for (int n = 3; n <= 9; n++) begin
      logic par, t0;
      par = (n % 2) == 1;
      t0  = (n == 3);
      if (n == 5) send_cfg(2'd3, 8'd7);
      if (n == 6) cfg_valid = 1'b0;
      step("d_off", FULL, ov(1'b1, {2'b11, t0}, {par, par, 1'b1}, 3'b110));
    end

    // Async reset while a request is pending
    do_reset();
    send_cfg(2'd1, 8'd5);
    step("e_idle", FULL, RST);
    cfg_valid = 1'b0;
    step("e_accept0", FULL, ov(1'b0, 3'b000, 3'b000, 3'b111));
    enable = 1'b1;
    send_cfg(2'd1, 8'd6);
    step("e_apply0", FULL, ov(1'b1, 3'b000, 3'b000, 3'b111));
    cfg_valid = 1'b0;
    step("e_pend", FULL, ov(1'b0, 3'b101, 3'b101, 3'b111));
    step("e_pend", FULL, ov(1'b0, 3'b101, 3'b000, 3'b111));
    reset = 1'b1;
    step("e_async", FULL, RST);
    step("e_hold", FULL, RST);
    reset  = 1'b0;
    enable = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      logic par;
      par = (n % 2) == 1;
      if (n == 0) step("e_post", FULL, RST);
      else step("e_post", FULL, ov(1'b1, 3'b111, {par, par, par}, 3'b111));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
